// File: rtl/uart_tx_fifo.sv
// UART transmitter with integrated baud divider and a small transmit FIFO.
// Frames (start, DATA_BITS data LSB first, optional parity, stop bits) are sent back-to-back.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage; pointers carry an extra wrap bit
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, empty, push, pop;
  logic [DATA_BITS-1:0] rd_data;

  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty        = (wr_ptr == rd_ptr);
  assign o_fifo_count = wr_ptr - rd_ptr;
  assign o_ready      = !full;
  assign push         = i_valid && !full;
  assign rd_data      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par, par_n;
  logic                 tx_n;
  logic                 par_load;

  assign par_load = (^rd_data) ^ (PARITY == 1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      o_tx    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par     <= par_n;
      o_tx    <= tx_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = rd_data;
          par_n   = par_load;
          state_n = S_START;
        end
      end
      S_START: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          state_n   = S_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            shift_n   = shift >> 1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          state_n   = S_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_n = '0;
            // Chain straight into the next start bit when a word is waiting
            if (!empty) begin
              pop     = 1'b1;
              shift_n = rd_data;
              par_n   = par_load;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Line level is registered from the next state so it aligns with the state register
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
  end

  assign o_busy = (state != S_IDLE) || !empty;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated baud divider and a small transmit FIFO. It replaces the fixed 8N1 transmitter and its separate baud clock. Everything runs on the single system clock, with no derived clocks. A producer pushes words through a valid/ready handshake, and the block serialises them back-to-back onto `o_tx` with a configurable data width, parity and stop-bit count.

## Interface
- `CLK_HZ`, default 12000000: system clock frequency.
- `BAUD`, default 9600: line rate. Bit period `DIV = (CLK_HZ + BAUD/2) / BAUD` cycles; `DIV >= 2` is required.
- `DATA_BITS`, default 8: data width, legal range 5..8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.
- `FIFO_DEPTH`, default 4: FIFO entries, a power of two, at least 2.

Ports:
- `i_clk` in 1: the single clock; all logic is on its rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_data` in DATA_BITS: word to transmit.
- `i_valid` in 1: producer has a word on `i_data`.
- `o_ready` out 1: FIFO can accept a word (`!full`).
- `o_tx` out 1: serial line; idles high. Registered.
- `o_busy` out 1: high while a frame is in progress or the FIFO is non-empty.
- `o_fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Push:** a word is written when `i_valid && o_ready` at a rising edge.
  - When full, `o_ready = 0` and `i_data` is ignored, even if a pop occurs on the same edge.
  - Push and pop on the same edge leave `o_fifo_count` unchanged.
- **Pop:** occurs only in IDLE with the FIFO non-empty, or at the end of the last stop bit with the FIFO non-empty. There is no bypass path: a word must be resident before it can be popped.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `o_tx = 1`. If the FIFO is non-empty: pop into the shift register, clear the baud counter, go to START.
  - START: `o_tx = 0` for DIV cycles, then go to DATA.
  - DATA: LSB first, DATA_BITS bits, DIV cycles each. Then go to PARITY if `PARITY != 0`, else STOP.
  - PARITY: one bit.
    - Odd: the count of ones in data plus parity is odd.
    - Even: that count is even.
    - Then go to STOP.
  - STOP: `o_tx = 1` for `STOP_BITS × DIV` cycles. Then, if the FIFO is non-empty, pop and go directly to START (zero idle gap); else go to IDLE.
- **Baud counter:** counts 0..DIV-1 only while not in IDLE. It is cleared on every frame start, so every bit lasts exactly DIV cycles and there is no phase jitter relative to the push.
- **Frame length:** `(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × DIV` cycles.
- **Width rules:**
  - Internal counters are sized from DIV, DATA_BITS and FIFO_DEPTH.
  - FIFO pointers carry one extra wrap bit. Full = addresses equal and wrap bits differ.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset values** (asserted asynchronously, immediately, including mid-frame):
  - `o_tx = 1`, `o_busy = 0`, `o_ready = 1`, `o_fifo_count = 0`.
  - FSM in IDLE; FIFO flushed; baud counter = 0.
- **Reset release:** the first push is accepted on the first rising edge after `i_rst_n` goes high.
- **Latency:** with the block idle and empty, a word accepted at edge E is popped at edge E+1. `o_tx` is low from edge E+1 through edge E+1+DIV.
- **`o_fifo_count`** updates on the edge after the push or pop.
- **`o_ready`** is derived combinationally from the registered count and deasserts in the cycle after the filling push.
- **`o_busy`** rises on the edge after the first accept. It falls on the edge that returns the FSM to IDLE with the FIFO empty.
- **`i_data`/`i_valid` changes** while `o_ready = 0` have no effect.

## Test plan
Benches use `CLK_HZ = 12000000` and `BAUD = 1000000` (DIV = 12) unless stated otherwise.

1. **Reset:** hold `i_rst_n = 0` with random `i_valid`/`i_data` → `o_tx = 1`, `o_ready = 1`, `o_busy = 0`, `o_fifo_count = 0` throughout.
2. **8N1, single push:** push 0x41 at edge E.
   - `o_tx` is low for 12 cycles from E+1.
   - Then bits 1,0,0,0,0,0,1,0 at 12 cycles each.
   - Then high; `o_busy` falls at E+1+120.
3. **Parity and stop bits:**
   - `PARITY = 2`, push 0x41 → parity bit 0.
   - `PARITY = 1`, push 0x41 → parity bit 1.
   - `STOP_BITS = 2`: stop bits high for 24 cycles; frame is 144 cycles with parity.
4. **FIFO full, `FIFO_DEPTH = 4`:** hold `i_valid = 1` for 6 consecutive edges with words 0x01..0x06.
   - 0x01..0x05 are accepted; 0x06 is rejected because `o_ready = 0` on the 6th edge.
   - Five frames follow back-to-back with no idle cycle between stop and start: 600 cycles total.
   - `o_fifo_count` peaks at 4.
5. **Reset mid-frame:** assert `i_rst_n = 0` during bit 3 of a frame with 2 words queued.
   - `o_tx = 1` immediately; count = 0.
   - After release, no further frame is sent without a new push.
6. **`DATA_BITS = 7`, PARITY = 2:** push 0x55 → start, bits 1,0,1,0,1,0,1, parity 0, stop; frame is 120 cycles. Bit 7 of the input is not transmitted.
